psum_binarize_pack: RTL and testbench

//  Downstream consumer of the convolution PE chain. Accepts the final outpsum of each PE chain

---
 rtl/cnn_pkg.sv | 46 ++++
 rtl/psum_channel_acc.sv | 80 ++++++++
 rtl/psum_binarize_pack.sv | 124 ++++++++++++
 tb/tb_psum_binarize_pack.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and arithmetic helpers for the psum binarize/pack datapath.
// Optional feature macro: PSUM_SAT_EN (selects the saturating accumulator add).
package cnn_pkg;

  localparam int PSUM_DATA_WIDTH_DEF = 12;
  localparam int ACC_WIDTH_DEF       = 16;

  typedef logic signed [PSUM_DATA_WIDTH_DEF-1:0] psum_t;
  typedef logic signed [ACC_WIDTH_DEF-1:0]       acc_t;

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } pack_state_e;

  // Sign-extend the low w bits of v to 32 bits (1 <= w <= 32).
  function automatic logic signed [31:0] sign_extend(input logic [31:0] v, input int unsigned w);
    logic signed [31:0] t;
    t = $signed(v << (32 - w));
    return t >>> (32 - w);
  endfunction

  // Add two values already in w-bit signed range (w <= 31) and clip the
  // result to that range; clipped reports whether clipping happened.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned        w,
                                                 output logic              clipped);
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    s  = a + b;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    clipped = 1'b0;
    if (s > hi) begin
      s       = hi;
      clipped = 1'b1;
    end else if (s < lo) begin
      s       = lo;
      clipped = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/psum_channel_acc.sv
// Per-pixel channel accumulator: counts channels, sums psums, flags pixel completion.
// Optional feature macro: PSUM_SAT_EN (saturating add plus sticky sat_flag).
module psum_channel_acc
  import cnn_pkg::*;
#(
  parameter int PSUM_DATA_WIDTH = 12,
  parameter int ACC_WIDTH       = 16,
  parameter int NUM_CHANNELS    = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       accept,
  input  logic [PSUM_DATA_WIDTH-1:0] in_psum,
  output logic                       pixel_done,
  output logic [ACC_WIDTH-1:0]       pixel_sum,
  output logic                       ch_cnt_next_zero
`ifdef PSUM_SAT_EN
  , output logic                     sat_flag
`endif
);

  localparam int CNT_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic [CNT_W-1:0]     ch_cnt_q, ch_cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 last_ch;
  logic signed [31:0]   ext_psum;
  logic signed [31:0]   add_base;
  logic signed [31:0]   sum32;
`ifdef PSUM_SAT_EN
  logic                 clip;
  logic                 sat_q, sat_d;
`endif

  // Next-state logic: first channel of a pixel starts from zero, later ones add to acc.
  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    ext_psum = sign_extend(32'(in_psum), PSUM_DATA_WIDTH);
    add_base = (ch_cnt_q == '0) ? 32'sd0 : sign_extend(32'(acc_q), ACC_WIDTH);
`ifdef PSUM_SAT_EN
    sum32    = sat_add(add_base, ext_psum, ACC_WIDTH, clip);
    sat_d    = sat_q | (accept & clip);
`else
    sum32    = add_base + ext_psum;
`endif
    pixel_sum  = ACC_WIDTH'(sum32);
    last_ch    = (ch_cnt_q == CNT_W'(NUM_CHANNELS - 1));
    pixel_done = accept & last_ch;
    acc_d      = acc_q;
    ch_cnt_d   = ch_cnt_q;
    if (accept) begin
      acc_d    = pixel_sum;
      ch_cnt_d = last_ch ? '0 : ch_cnt_q + CNT_W'(1);
    end
    ch_cnt_next_zero = (ch_cnt_d == '0);
  end

  // Accumulator and channel counter registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_cnt_q <= '0;
      acc_q    <= '0;
`ifdef PSUM_SAT_EN
      sat_q    <= 1'b0;
`endif
    end else begin
      ch_cnt_q <= ch_cnt_d;
      acc_q    <= acc_d;
`ifdef PSUM_SAT_EN
      sat_q    <= sat_d;
`endif
    end
  end

`ifdef PSUM_SAT_EN
  assign sat_flag = sat_q;
`endif

endmodule

// File: rtl/psum_binarize_pack.sv
// Binarizes accumulated pixel sums by threshold and packs bits LSB-first into words.
// Optional feature macro: PSUM_SAT_EN (saturating accumulator, adds sat_flag output).
module psum_binarize_pack
  import cnn_pkg::*;
#(
  parameter int PSUM_DATA_WIDTH = 12,
  parameter int ACC_WIDTH       = 16,
  parameter int NUM_CHANNELS    = 4,
  parameter int PACK_WIDTH      = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [PSUM_DATA_WIDTH-1:0]        in_psum,
  input  logic [ACC_WIDTH-1:0]              threshold,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PACK_WIDTH-1:0]             out_bits,
  output logic [$clog2(PACK_WIDTH+1)-1:0]   out_count
`ifdef PSUM_SAT_EN
  , output logic                            sat_flag
`endif
);

  localparam int COUNT_W = $clog2(PACK_WIDTH + 1);

  pack_state_e          state_q, state_d;
  logic [PACK_WIDTH-1:0] pack_q, pack_d, pack_next;
  logic [COUNT_W-1:0]   bit_idx_q, bit_idx_d, count_next;
  logic                 flush_pend_q, flush_pend_d;
  logic [PACK_WIDTH-1:0] out_bits_q, out_bits_d;
  logic [COUNT_W-1:0]   out_count_q, out_count_d;

  logic                 accept, xfer, out_free;
  logic                 pixel_done, ch_cnt_next_zero, pix_bit;
  logic [ACC_WIDTH-1:0] pixel_sum;
  logic                 pend, honour, word_done, emit;

  assign out_valid = (state_q == S_HOLD);
  assign out_free  = !out_valid | out_ready;
  assign in_ready  = out_free;
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign out_bits  = out_bits_q;
  assign out_count = out_count_q;

  psum_channel_acc #(
    .PSUM_DATA_WIDTH (PSUM_DATA_WIDTH),
    .ACC_WIDTH       (ACC_WIDTH),
    .NUM_CHANNELS    (NUM_CHANNELS)
  ) u_acc (
    .clk              (clk),
    .reset_n          (reset_n),
    .accept           (accept),
    .in_psum          (in_psum),
    .pixel_done       (pixel_done),
    .pixel_sum        (pixel_sum),
    .ch_cnt_next_zero (ch_cnt_next_zero)
`ifdef PSUM_SAT_EN
    , .sat_flag       (sat_flag)
`endif
  );

  // Compare, pack, flush arbitration and output-register next state.
  always_comb begin
    state_d      = state_q;
    pack_d       = pack_q;
    bit_idx_d    = bit_idx_q;
    out_bits_d   = out_bits_q;
    out_count_d  = out_count_q;

    pix_bit   = ($signed(pixel_sum) >= $signed(threshold));
    pack_next = pack_q;
    for (int i = 0; i < PACK_WIDTH; i++) begin
      if (pixel_done && (bit_idx_q == COUNT_W'(i))) pack_next[i] = pix_bit;
    end
    count_next = bit_idx_q + COUNT_W'(pixel_done);
    word_done  = pixel_done & (bit_idx_q == COUNT_W'(PACK_WIDTH - 1));

    // A flush pulse counts as pending in its own cycle; it is honoured only at a
    // pixel boundary with the output register able to take a word.
    pend         = flush_pend_q | flush;
    honour       = pend & ch_cnt_next_zero & out_free;
    flush_pend_d = pend & ~honour;
    emit         = word_done | (honour & (count_next != '0));

    if (pixel_done) begin
      pack_d    = pack_next;
      bit_idx_d = count_next;
    end

    if (emit) begin
      out_bits_d  = pack_next;
      out_count_d = count_next;
      pack_d      = '0;
      bit_idx_d   = '0;
      state_d     = S_HOLD;
    end else if (xfer) begin
      state_d     = S_FILL;
    end
  end

  // FSM, pack register and output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_FILL;
      pack_q       <= '0;
      bit_idx_q    <= '0;
      flush_pend_q <= 1'b0;
      out_bits_q   <= '0;
      out_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      pack_q       <= pack_d;
      bit_idx_q    <= bit_idx_d;
      flush_pend_q <= flush_pend_d;
      out_bits_q   <= out_bits_d;
      out_count_q  <= out_count_d;
    end
  end

endmodule

// File: tb/tb_psum_binarize_pack.sv
// Scoreboard bench for psum_binarize_pack: directed pixels, queued expected words,
// independent monitors. A second instance with ACC_WIDTH=12 covers overflow.
module tb_psum_binarize_pack;

  localparam int PW = 12;
  localparam int AW = 16;
  localparam int NC = 4;
  localparam int KW = 8;
  localparam int CW = $clog2(KW + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [PW-1:0] in_psum;
  logic [AW-1:0] threshold;
  logic [KW-1:0] out_bits;
  logic [CW-1:0] out_count;

  logic          in_valid2, in_ready2, out_valid2;
  logic          out_ready2 = 1'b1;
  logic          flush2 = 1'b0;
  logic [PW-1:0] in_psum2;
  logic [11:0]   threshold2;
  logic [KW-1:0] out_bits2;
  logic [CW-1:0] out_count2;
`ifdef PSUM_SAT_EN
  logic          sat_flag, sat_flag2;
`endif

  psum_binarize_pack #(.PSUM_DATA_WIDTH(PW), .ACC_WIDTH(AW), .NUM_CHANNELS(NC), .PACK_WIDTH(KW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
    .threshold(threshold), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .out_count(out_count)
`ifdef PSUM_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  psum_binarize_pack #(.PSUM_DATA_WIDTH(PW), .ACC_WIDTH(12), .NUM_CHANNELS(NC), .PACK_WIDTH(KW)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_psum(in_psum2),
    .threshold(threshold2), .flush(flush2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_bits(out_bits2), .out_count(out_count2)
`ifdef PSUM_SAT_EN
    , .sat_flag(sat_flag2)
`endif
  );

  typedef struct packed {
    logic [KW-1:0] bits;
    logic [CW-1:0] cnt;
  } word_t;

  word_t exp_q[$];
  word_t exp2_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [KW-1:0] b, input int c);
    word_t w;
    w.bits = b;
    w.cnt  = CW'(c);
    exp_q.push_back(w);
  endtask

  // Offer one psum to the main instance until accepted (bounded).
  task automatic send(input int p);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_psum  = PW'(p);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'(done), 32'd1);
  endtask

  task automatic send2(input int p);
    bit done = 1'b0;
    in_valid2 = 1'b1;
    in_psum2  = PW'(p);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = in_ready2;
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    if (!done) check("send2_timeout", 32'(done), 32'd1);
  endtask

  // Pixel summing to 7 (bit 1 at threshold 7) or 6 (bit 0 at threshold 7).
  task automatic pix7();
    send(3); send(-2); send(5); send(1);
  endtask

  task automatic pix6();
    send(3); send(-2); send(5); send(0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_out_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) check(name, 32'(seen), 32'd1);
  endtask

  // Monitor for the main instance: pops on every transfer, and checks that a
  // stalled word stays put until it is taken.
  initial begin
    bit    hold_prev = 1'b0;
    word_t held;
    word_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_bits", 32'(out_bits), 32'(held.bits));
          check("hold_count", 32'(out_count), 32'(held.cnt));
        end
        if (out_valid && out_ready) begin
          check("word_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_bits", 32'(out_bits), 32'(e.bits));
            check("out_count", 32'(out_count), 32'(e.cnt));
          end
        end
        hold_prev = out_valid && !out_ready;
        held.bits = out_bits;
        held.cnt  = out_count;
      end
    end
  end

  // Monitor for the narrow-accumulator instance.
  initial begin
    word_t e;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid2 && out_ready2) begin
        check("word2_expected", 32'(exp2_q.size() > 0), 32'd1);
        if (exp2_q.size() > 0) begin
          e = exp2_q.pop_front();
          check("out_bits2", 32'(out_bits2), 32'(e.bits));
          check("out_count2", 32'(out_count2), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w2;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_psum    = '0;
    threshold  = AW'(7);
    flush      = 1'b0;
    out_ready  = 1'b1;
    in_valid2  = 1'b0;
    in_psum2   = '0;
    threshold2 = 12'd0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bits", 32'(out_bits), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: eight identical pixels of sum 7, threshold 7 -> all ones, valid right after last accept
    push(8'hFF, 8);
    for (int p = 0; p < 8; p++) pix7();
    check("t1_latency", 32'(out_valid), 32'd1);

    // 2: alternating sums 7/6 at threshold 7, then at threshold -100
    push(8'h55, 8);
    for (int p = 0; p < 4; p++) begin pix7(); pix6(); end
    threshold = -AW'(100);
    push(8'hFF, 8);
    for (int p = 0; p < 4; p++) begin pix7(); pix6(); end
    threshold = AW'(7);

    // 3: downstream stalls 20 cycles after word 1 while more pixels are fed
    out_ready = 1'b0;
    push(8'hFF, 8);
    push(8'h55, 8);
    fork
      begin
        for (int p = 0; p < 8; p++) pix7();
        for (int p = 0; p < 4; p++) begin pix7(); pix6(); end
      end
      begin
        wait_out_valid("t3_word1_timeout");
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t3_in_ready_stalled", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join

    // 4: bits 1,0,1 then flush in the middle of the 4th pixel (bit 1) -> 0x0D / 4
    push(8'h0D, 4);
    pix7(); pix6(); pix7();
    send(3); send(-2);
    pulse_flush();
    send(5); send(1);
    repeat (3) @(posedge clk);
    #1;
    pulse_flush();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_empty_flush_no_word", 32'(out_valid), 32'd0);
    end

    // 5: +2047 x4 into a 12-bit accumulator, threshold 0
`ifdef PSUM_SAT_EN
    w2.bits = 8'hFF;
`else
    w2.bits = 8'h00;
`endif
    w2.cnt = CW'(8);
    exp2_q.push_back(w2);
    for (int p = 0; p < 8; p++) begin
      send2(2047); send2(2047); send2(2047); send2(2047);
    end
    repeat (3) @(posedge clk);
    #1;
`ifdef PSUM_SAT_EN
    check("t5_sat_flag", 32'(sat_flag2), 32'd1);
    check("t5_main_no_sat", 32'(sat_flag), 32'd0);
`endif

    // 6: reset after 5 bits and 2 channels, then a fresh word with no stale bits
    for (int p = 0; p < 5; p++) pix7();
    send(3); send(-2);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_out_bits", 32'(out_bits), 32'd0);
    check("t6_out_count", 32'(out_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    push(8'h55, 8);
    for (int p = 0; p < 4; p++) begin pix7(); pix6(); end

    // Drain
    for (int i = 0; i < 100 && (exp_q.size() > 0 || exp2_q.size() > 0); i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("drain_main", 32'(exp_q.size()), 32'd0);
    check("drain_narrow", 32'(exp2_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
